alu_exec: RTL
=============

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 Parameter WIDTH, default 16, operand/result data width.
REQ-002 Parameter RIDX_W, default 6, destination register index width (matches 6-bit operand field).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 in_valid  input  1  decoded instruction presented.
REQ-006 in_ready  output  1  block can accept an instruction this cycle.
REQ-007 in_opcode  input  4  instruction opcode.
REQ-008 in_a  input  WIDTH  first operand value (register read of operand_1).
REQ-009 in_b  input  WIDTH  second operand value (register read or immediate of operand_2).
REQ-010 in_dst  input  RIDX_W  destination register index.
REQ-011 out_valid  output  1  result held and valid.
REQ-012 out_ready  input  1  write-result stage consumes result.
REQ-013 out_result  output  WIDTH  computed result.
REQ-014 out_dst  output  RIDX_W  registered copy of in_dst.
REQ-015 out_wr_en  output  1  result requires register writeback.
REQ-016 out_flags  output  3  {neg, carry, zero}.
REQ-017 out_err  output  1  illegal opcode executed.

Function
REQ-018 States SHALL be IDLE, MUL, DONE; in_ready SHALL equal (state==IDLE).
REQ-019 Accept SHALL occur on an edge with in_valid && in_ready; opcode, a, b, dst SHALL be captured at that edge.
REQ-020 Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 NOT a, 7 SHL a by b[3:0], 8 SHR (logical) a by b[3:0], 9 MUL, 10 CMP, 11 MOV b; 12-15 illegal.
REQ-021 Non-MUL accept SHALL go IDLE->DONE; out_valid SHALL rise the cycle after accept (latency 1).
REQ-022 MUL accept SHALL go IDLE->MUL for exactly 16 cycles (one shift-add step per cycle), then DONE; out_valid rises 17 cycles after accept.
REQ-023 DONE->IDLE SHALL occur on an edge with out_valid && out_ready; outputs SHALL hold stable while out_valid && !out_ready.
REQ-024 Arithmetic SHALL be unsigned modulo 2^WIDTH; MUL result SHALL be low WIDTH bits of the 2*WIDTH product.
REQ-025 carry: ADD carry-out; SUB/CMP borrow (a<b); SHL last bit shifted out of MSB; SHR last bit shifted out of LSB; MUL 1 if upper product half nonzero; shift by 0 and all other ops carry=0.
REQ-026 zero = (out_result==0); neg = out_result[WIDTH-1], for every opcode.
REQ-027 CMP SHALL compute a-b for flags only, out_wr_en=0; NOP out_result=0, out_wr_en=0.
REQ-028 Illegal opcode SHALL complete in 1 cycle with out_err=1, out_wr_en=0, out_result=0.
REQ-029 out_wr_en SHALL be 1 for opcodes 1-9 and 11.
REQ-030 in_valid during MUL or DONE SHALL be ignored (no capture, no state change).
REQ-031 out_ready asserted while out_valid=0 SHALL have no effect.

Reset
REQ-032 rst=0 SHALL immediately force state=IDLE, out_valid=0, out_result=0, out_dst=0, out_wr_en=0, out_flags=0, out_err=0, multiplier step counter=0.
REQ-033 Reset during MUL or DONE SHALL abort the operation; no result SHALL appear after reset release.
REQ-034 in_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-035 Opcode constants, state encodings and flag bit positions SHALL live in shared package alu_pkg.
REQ-036 The iterative multiplier SHALL be sub-module mul_seq (start, a, b -> done, 2*WIDTH product, 4-bit step counter), same clk/rst.
REQ-037 All outputs SHALL be driven from registers.

Verification
REQ-038 ADD a=16'hFFFF b=16'h0001 -> next cycle out_result=0, flags zero=1 carry=1 neg=0, out_wr_en=1.
REQ-039 SUB a=3 b=5 -> out_result=16'hFFFE, carry=1, neg=1, zero=0; CMP same operands -> same flags, out_wr_en=0.
REQ-040 MUL a=300 b=300 -> out_valid exactly 17 cycles after accept, out_result=16'h5F90, carry=1; in_ready=0 throughout.
REQ-041 SHL a=16'h8001 b=1 -> out_result=16'h0002, carry=1; out_ready held 0 for 5 cycles -> outputs stable, second in_valid ignored.
REQ-042 Opcode 13 -> out_err=1, out_wr_en=0, out_result=0, latency 1.
REQ-043 rst=0 asserted at MUL step 8 -> outputs zero immediately; after release in_ready=1, out_valid stays 0 until a new accept.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the execute stage: opcodes, FSM states, flag bits.
`timescale 1ns/1ps
package alu_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_NOT = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;
  localparam logic [3:0] OP_CMP = 4'd10;
  localparam logic [3:0] OP_MOV = 4'd11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int FLG_ZERO  = 0;
  localparam int FLG_CARRY = 1;
  localparam int FLG_NEG   = 2;

  function automatic logic op_writes(input logic [3:0] op);
    return ((op >= OP_ADD) && (op <= OP_MUL)) || (op == OP_MOV);
  endfunction

endpackage

// File: rtl/alu_exec_mul_seq.sv
// Iterative shift-add multiplier: 16 steps, the first taken on the start edge.
`timescale 1ns/1ps
module mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [3:0]         step
);

  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [3:0]         step_q, step_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  always_comb begin
    busy_d   = busy_q;
    done_d   = 1'b0;
    step_d   = step_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    if (start) begin
      busy_d   = 1'b1;
      step_d   = 4'd1;
      prod_d   = b[0] ? {{WIDTH{1'b0}}, a} : '0;
      mcand_d  = {{WIDTH{1'b0}}, a} << 1;
      mplier_d = b >> 1;
    end else if (busy_q) begin
      if (mplier_q[0]) prod_d = prod_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      step_d   = step_q + 4'd1;
      // step wraps to 0 as the final partial product lands
      if (step_q == 4'd15) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      step_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else begin
      busy_q   <= busy_d;
      done_q   <= done_d;
      step_q   <= step_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
    end
  end

  assign done    = done_q;
  assign product = prod_q;
  assign step    = step_q;

endmodule

// File: rtl/alu_exec.sv
// Execute stage: single-cycle ALU ops plus a 16-step multiplier,
// valid/ready on both sides, all outputs registered.
`timescale 1ns/1ps
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int RIDX_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_opcode,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic [RIDX_W-1:0] in_dst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_result,
  output logic [RIDX_W-1:0] out_dst,
  output logic              out_wr_en,
  output logic [2:0]        out_flags,
  output logic              out_err
);

  logic [1:0]        state_q, state_d;
  logic              rdy_q, rdy_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_result_q, out_result_d;
  logic [RIDX_W-1:0] out_dst_q, out_dst_d;
  logic              out_wr_en_q, out_wr_en_d;
  logic [2:0]        out_flags_q, out_flags_d;
  logic              out_err_q, out_err_d;

  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [3:0]         mul_step;

  logic [WIDTH:0]    ext;
  logic [WIDTH-1:0]  alu_res;
  logic              alu_cy;
  logic              alu_err;
  logic [3:0]        sh;

  mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (in_a),
    .b       (in_b),
    .done    (mul_done),
    .product (mul_prod),
    .step    (mul_step)
  );

  always_comb begin
    ext     = '0;
    alu_res = '0;
    alu_cy  = 1'b0;
    alu_err = 1'b0;
    sh      = in_b[3:0];
    unique case (in_opcode)
      OP_NOP, OP_MUL: ;
      OP_ADD: begin
        ext     = {1'b0, in_a} + {1'b0, in_b};
        alu_res = ext[WIDTH-1:0];
        alu_cy  = ext[WIDTH];
      end
      OP_SUB, OP_CMP: begin
        alu_res = in_a - in_b;
        alu_cy  = (in_a < in_b);
      end
      OP_AND: alu_res = in_a & in_b;
      OP_OR:  alu_res = in_a | in_b;
      OP_XOR: alu_res = in_a ^ in_b;
      OP_NOT: alu_res = ~in_a;
      // extra bit above/below catches the last bit shifted out
      OP_SHL: begin
        ext     = {1'b0, in_a} << sh;
        alu_res = ext[WIDTH-1:0];
        alu_cy  = ext[WIDTH];
      end
      OP_SHR: begin
        ext     = {in_a, 1'b0} >> sh;
        alu_res = ext[WIDTH:1];
        alu_cy  = ext[0];
      end
      OP_MOV: alu_res = in_b;
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_dst_d    = out_dst_q;
    out_wr_en_d  = out_wr_en_q;
    out_flags_d  = out_flags_q;
    out_err_d    = out_err_q;
    mul_start    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          out_dst_d = in_dst;
          if (in_opcode == OP_MUL) begin
            state_d   = ST_MUL;
            mul_start = 1'b1;
          end else begin
            state_d                = ST_DONE;
            out_valid_d            = 1'b1;
            out_result_d           = alu_res;
            out_wr_en_d            = op_writes(in_opcode);
            out_err_d              = alu_err;
            out_flags_d[FLG_NEG]   = alu_res[WIDTH-1];
            out_flags_d[FLG_CARRY] = alu_cy;
            out_flags_d[FLG_ZERO]  = (alu_res == '0);
          end
        end
      end
      ST_MUL: begin
        if (mul_done && (mul_step == 4'd0)) begin
          state_d                = ST_DONE;
          out_valid_d            = 1'b1;
          out_result_d           = mul_prod[WIDTH-1:0];
          out_wr_en_d            = 1'b1;
          out_err_d              = 1'b0;
          out_flags_d[FLG_NEG]   = mul_prod[WIDTH-1];
          out_flags_d[FLG_CARRY] = |mul_prod[2*WIDTH-1:WIDTH];
          out_flags_d[FLG_ZERO]  = (mul_prod[WIDTH-1:0] == '0);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    rdy_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      rdy_q        <= 1'b1;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_dst_q    <= '0;
      out_wr_en_q  <= 1'b0;
      out_flags_q  <= '0;
      out_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rdy_q        <= rdy_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_dst_q    <= out_dst_d;
      out_wr_en_q  <= out_wr_en_d;
      out_flags_q  <= out_flags_d;
      out_err_q    <= out_err_d;
    end
  end

  assign in_ready   = rdy_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_dst    = out_dst_q;
  assign out_wr_en  = out_wr_en_q;
  assign out_flags  = out_flags_q;
  assign out_err    = out_err_q;

endmodule
